trigger_capture: RTL and testbench



---
 rtl/trigger_capture.sv | 172 +++++++++++++++++
 tb/tb_trigger_capture.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// Threshold-triggered capture buffer: pre-fills PRETRIG samples, waits for a crossing,
// fills the rest of the screen, then freezes for column readout. Optional macro: TRIGGER_AUTO_EN.
module trigger_capture #(
    parameter int DEPTH        = 640,
    parameter int WIDTH        = 10,
    parameter int PRETRIG      = 64,
    parameter int AUTO_TIMEOUT = 100000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_level,
    input  logic             i_rising,
    input  logic             i_arm,
    input  logic [9:0]       i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [1:0]       o_state,
    output logic             o_triggered
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
    localparam logic [PW:0]   DEPTH_S = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PRE_W   = PW'(PRETRIG);
    localparam logic [PW-1:0] POST_W  = PW'(DEPTH - PRETRIG);

    typedef enum logic [1:0] {ST_PRE = 2'd0, ST_WAIT = 2'd1, ST_POST = 2'd2, ST_HOLD = 2'd3} state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_reg, state_next;
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    cnt_reg, cnt_next;
    logic [PW-1:0]    start_reg, start_next;
    logic [WIDTH-1:0] prev_reg, prev_next;
    logic             prev_valid_reg, prev_valid_next;
    logic             triggered_reg, triggered_next;
    logic [WIDTH-1:0] rd_data_reg;

    logic             accept;
    logic             crossing;
    logic             auto_fire;
    logic             rd_oob;
    logic [PW:0]      rd_sum;
    logic [PW-1:0]    rd_idx;

`ifdef TRIGGER_AUTO_EN
    localparam int AC = $clog2(AUTO_TIMEOUT + 1);
    logic [AC-1:0] auto_cnt_reg, auto_cnt_next;
    assign auto_fire = (auto_cnt_reg == AC'(AUTO_TIMEOUT - 1));
`else
    assign auto_fire = 1'b0;
`endif

    assign accept   = i_valid && (state_reg != ST_HOLD);
    assign crossing = prev_valid_reg &&
                      (i_rising ? (prev_reg < i_level && i_data >= i_level)
                                : (prev_reg > i_level && i_data <= i_level));

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        cnt_next        = cnt_reg;
        start_next      = start_reg;
        prev_next       = prev_reg;
        prev_valid_next = prev_valid_reg;
        triggered_next  = 1'b0;
`ifdef TRIGGER_AUTO_EN
        auto_cnt_next   = auto_cnt_reg;
`endif
        if (accept) begin
            wr_ptr_next     = (wr_ptr_reg == LAST) ? '0 : wr_ptr_reg + 1'b1;
            prev_next       = i_data;
            prev_valid_next = 1'b1;
        end
        case (state_reg)
            ST_PRE: begin
                if (accept) begin
                    if (cnt_reg == PRE_W - 1'b1) begin
                        state_next = ST_WAIT;
                        cnt_next   = '0;
`ifdef TRIGGER_AUTO_EN
                        auto_cnt_next = '0;
`endif
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    if (crossing || auto_fire) begin
                        triggered_next = 1'b1;
                        // Start of the frozen window, PRETRIG slots behind the trigger address.
                        start_next = (wr_ptr_reg >= PRE_W) ? wr_ptr_reg - PRE_W
                                                           : wr_ptr_reg + POST_W;
                        cnt_next   = PW'(1);
                        state_next = (POST_W == PW'(1)) ? ST_HOLD : ST_POST;
                    end else begin
`ifdef TRIGGER_AUTO_EN
                        auto_cnt_next = auto_cnt_reg + 1'b1;
`endif
                    end
                end
            end
            ST_POST: begin
                if (accept) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_reg == POST_W - 1'b1) begin
                        state_next = ST_HOLD;
                    end
                end
            end
            default: begin
                if (i_arm) begin
                    state_next      = ST_PRE;
                    cnt_next        = '0;
                    prev_valid_next = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_PRE;
            wr_ptr_reg     <= '0;
            cnt_reg        <= '0;
            start_reg      <= '0;
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
            triggered_reg  <= 1'b0;
`ifdef TRIGGER_AUTO_EN
            auto_cnt_reg   <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            cnt_reg        <= cnt_next;
            start_reg      <= start_next;
            prev_reg       <= prev_next;
            prev_valid_reg <= prev_valid_next;
            triggered_reg  <= triggered_next;
`ifdef TRIGGER_AUTO_EN
            auto_cnt_reg   <= auto_cnt_next;
`endif
        end
    end

    // Column index rotated by start; both operands are below DEPTH so one subtract suffices.
    assign rd_oob = (32'(i_rd_addr) >= 32'(DEPTH));
    assign rd_sum = {1'b0, start_reg} + {1'b0, i_rd_addr[PW-1:0]};
    assign rd_idx = (rd_sum >= DEPTH_S) ? PW'(rd_sum - DEPTH_S) : rd_sum[PW-1:0];

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || rd_oob) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    assign o_rd_data   = rd_data_reg;
    assign o_state     = state_reg;
    assign o_triggered = triggered_reg;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: ramps, falling edge, arm/reset handling, auto timeout.
module tb_trigger_capture;
    logic       clk = 1'b0;
    logic       i_rst, i_valid, i_rising, i_arm;
    logic [9:0] i_data, i_level, i_rd_addr, o_rd_data;
    logic [1:0] o_state;
    logic       o_triggered;

    int checks   = 0;
    int failures = 0;
    int trig_pulses = 0;

    always #5 clk = ~clk;

    trigger_capture #(.DEPTH(640), .WIDTH(10), .PRETRIG(64), .AUTO_TIMEOUT(1000)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .i_level(i_level), .i_rising(i_rising), .i_arm(i_arm), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_state(o_state), .o_triggered(o_triggered)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_triggered === 1'b1) trig_pulses++;
    endtask

    task automatic send(input int v);
        i_valid = 1'b1;
        i_data  = 10'(v);
        tick();
        i_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input int addr, input int exp);
        i_rd_addr = 10'(addr);
        tick();
        check_val(tag, 32'(o_rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        trig_pulses = 0;
    endtask

    initial begin
        int bad;
        i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_level = 10'd512;
        i_rising = 1'b1; i_arm = 1'b0; i_rd_addr = '0;
        tick();
        tick();
        i_rst = 1'b0;
        check_val("reset_state", 32'(o_state), 0);
        check_val("reset_trig", 32'(o_triggered), 0);
        check_val("reset_rd", 32'(o_rd_data), 0);

        // 1: rising ramp, level 512
        for (int k = 0; k < 64; k++) send(k);
        check_val("t1_wait_after_pre", 32'(o_state), 1);
        for (int k = 64; k < 512; k++) send(k);
        check_val("t1_still_wait", 32'(o_state), 1);
        send(512);
        check_val("t1_post", 32'(o_state), 2);
        check_val("t1_trig_pulse", 32'(o_triggered), 1);
        for (int k = 513; k < 1087; k++) send(k % 1024);
        check_val("t1_post_575", 32'(o_state), 2);
        send(1087 % 1024);
        check_val("t1_hold", 32'(o_state), 3);
        send(999);
        check_val("t1_hold_ignores_valid", 32'(o_state), 3);
        check_val("t1_one_pulse", 32'(trig_pulses), 1);
        rd("t1_rd64", 64, 512);
        rd("t1_rd0", 0, 448);
        rd("t1_rd639", 639, 63);

        // 2: ramp from 500, crossing inside PRE ignored
        do_reset();
        i_level = 10'd520;
        for (int k = 0; k < 1620; k++) begin
            send((500 + k) % 1024);
            if (k == 1043) check_val("t2_wait_before", 32'(o_state), 1);
            if (k == 1044) check_val("t2_post", 32'(o_state), 2);
        end
        check_val("t2_hold", 32'(o_state), 3);
        check_val("t2_one_pulse", 32'(trig_pulses), 1);
        rd("t2_rd64", 64, 520);
        rd("t2_rd63", 63, 519);

        // 3: falling edge, descending ramp, level 300
        do_reset();
        i_rising = 1'b0;
        i_level  = 10'd300;
        for (int k = 0; k < 1299; k++) begin
            send((1023 - k) & 1023);
            if (k == 723) check_val("t3_post", 32'(o_state), 2);
        end
        check_val("t3_hold", 32'(o_state), 3);
        rd("t3_rd64", 64, 300);
        rd("t3_rd63", 63, 301);
        rd("t3_rd0", 0, 364);

        // 6: out-of-range column
        rd("t6_rd700", 700, 0);

        // 4: arm with simultaneous valid, arm in WAIT, reset in POST
        i_arm = 1'b1; i_valid = 1'b1; i_data = 10'd500;
        tick();
        i_arm = 1'b0; i_valid = 1'b0;
        check_val("t4_arm_pre", 32'(o_state), 0);
        for (int k = 0; k < 63; k++) send(0);
        check_val("t4_dropped_sample", 32'(o_state), 0);
        send(0);
        check_val("t4_wait", 32'(o_state), 1);
        i_arm = 1'b1;
        send(0);
        i_arm = 1'b0;
        check_val("t4_arm_in_wait", 32'(o_state), 1);
        send(400);
        send(200);
        check_val("t4_post", 32'(o_state), 2);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check_val("t4_rst_state", 32'(o_state), 0);
        check_val("t4_rst_rd", 32'(o_rd_data), 0);
        check_val("t4_rst_trig", 32'(o_triggered), 0);

        // 5: constant 100 below the level
        do_reset();
        i_rising = 1'b1;
        i_level  = 10'd512;
        for (int k = 0; k < 64; k++) send(100);
        check_val("t5_wait", 32'(o_state), 1);
`ifdef TRIGGER_AUTO_EN
        for (int k = 0; k < 999; k++) send(100);
        check_val("t5_wait_999", 32'(o_state), 1);
        send(100);
        check_val("t5_auto_post", 32'(o_state), 2);
        check_val("t5_auto_trig", 32'(o_triggered), 1);
        for (int k = 0; k < 575; k++) send(100);
        check_val("t5_hold", 32'(o_state), 3);
        rd("t5_rd0", 0, 100);
        rd("t5_rd64", 64, 100);
        rd("t5_rd639", 639, 100);
`else
        bad = 0;
        for (int k = 0; k < 5000; k++) begin
            send(100);
            if (o_state !== 2'd1) bad++;
        end
        check_val("t5_stays_wait", 32'(bad), 0);
        check_val("t5_no_trig", 32'(trig_pulses), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
